timer_display_scan: RTL
=======================

# timer_display_scan

Two-digit multiplexed seven-segment driver for the countdown timer's BCD outputs: it consumes tens/units digits and the overtime indication, and drives a shared segment bus with per-digit enables. Each scan frame works from one coherent snapshot of both digits. The block adds leading-zero blanking, a dash for invalid BCD, and a sticky overtime flag that blinks the display. It sits between the timer and the board's common-anode display.

## Interface
- SCAN_DIV, 25000: CLK cycles per digit slot (≥2).
- BLINK_DIV, 12500000: CLK cycles per blink half-period (≥2).
- LZB, 1: when 1, blank the tens digit when it is 0.
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- Display_En  in  1  0 = display dark and overtime flag cleared.
- TimerH  in  4  tens digit, BCD.
- TimerL  in  4  units digit, BCD.
- Time_Over  in  1  overtime indication (may be a short pulse).
- Seg  out  7  {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal point, active-low; always 1 (off).
- Dig_Sel  out  2  digit enables, active-low; bit0 = units, bit1 = tens.
- Overtime_Flag  out  1  sticky overtime status.

## Operation
- Scan counter: 0..SCAN_DIV-1. The cycle it equals SCAN_DIV-1 is a "tick", and the counter wraps to 0 on a tick.
- Digit index: toggles on each tick. Index 0 = units, 1 = tens.
- Snapshot: on the tick that moves the index 1→0, register TimerH and TimerL together. The whole following frame displays only the snapshot.
- Decode (units and tens): 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10. Values 10–15→7'h3F (dash).
- Leading-zero blanking: when LZB=1 and the tens snapshot is 0, the tens slot shows Seg=7'h7F with Dig_Sel[1] still asserted.
- Overtime flag: set on a Time_Over rising edge, detected with a one-cycle registered previous value. It stays set until RST, or until Display_En=0 is sampled. If set and clear occur in the same cycle, clear wins.
- Blink: the blink counter runs only while the flag is set, and reset/clear restore both the blink counter and the phase to 0. The phase toggles every BLINK_DIV cycles, starting at phase 1 (visible) when the flag sets. During phase 0, Dig_Sel=2'b11.
- Display_En=0: Dig_Sel=2'b11 and Seg=7'h7F. The scan and snapshot logic keeps running.

## Timing
- All outputs are registered.
- Reset values:
  - Seg=7'h7F, DP=1, Dig_Sel=2'b11, Overtime_Flag=0.
  - Scan counter, digit index, blink counter and phase = 0.
  - Snapshot = 0/0.
- Ghost blanking: in the cycle after a tick, Dig_Sel=2'b11 and Seg=7'h7F. From the second cycle after the tick until the next tick's blank cycle, the new digit is driven.
- Input latency: inputs are captured at the start of a frame and first appear two cycles after the 1→0 tick. Worst case is about 2·SCAN_DIV+2 cycles.
- Overtime_Flag rises one cycle after Time_Over is sampled high with its previous value low. A 1-cycle Time_Over pulse must be caught.
- Changing TimerH/TimerL mid-frame has no visible effect until the next snapshot.
- Reset asserted mid-frame forces the reset values immediately. After release, scanning restarts at index 0 with a zero snapshot.

## Structure
- Package timer_disp_pkg:
  - segment constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F;
  - the 16-entry BCD-to-segment table;
  - digit index encodings UNITS=0 and TENS=1.
- Sub-module seg7_bcd_decode: combinational 4-bit to 7-bit using the package table. It is instantiated once and fed by a mux on the digit index.

## Test plan
Use SCAN_DIV=4, BLINK_DIV=16.
- Reset, snapshot and frame order:
  - Stimulus: RST pulse, then Display_En=1, TimerH=3, TimerL=0.
  - Response: after the first 1→0 tick and its blank cycle, the units slot shows Dig_Sel=2'b10 with Seg=7'h40. It is followed by the tens slot, Dig_Sel=2'b01 with Seg=7'h30, with one blank cycle between slots.
- Coherent snapshot:
  - Stimulus: change TimerH/TimerL from 2/0 to 1/9 in the middle of the units slot.
  - Response: the current frame still shows 0 then 2 (7'h40, 7'h24). The next frame shows 9 then 1 (7'h10, 7'h79).
- Leading zero and invalid BCD:
  - Stimulus: TimerH=0, TimerL=5 with LZB=1.
  - Response: the tens slot shows Seg=7'h7F and the units slot shows 7'h12.
  - Stimulus: TimerL=4'hC.
  - Response: the units slot shows 7'h3F.
- Overtime blink:
  - Stimulus: a 1-cycle Time_Over pulse.
  - Response: Overtime_Flag=1 one cycle later. Digits are visible for 16 cycles, then Dig_Sel=2'b11 for 16 cycles, repeating.
  - Stimulus: Display_En=0.
  - Response: flag cleared and display dark.
- Simultaneous set and clear:
  - Stimulus: a Time_Over rising edge in the same cycle as Display_En=0.
  - Response: Overtime_Flag stays 0.
- Reset mid-operation:
  - Stimulus: assert RST during the tens slot while blinking.
  - Response: in the same cycle, Seg=7'h7F, Dig_Sel=2'b11 and Overtime_Flag=0. After release, the first lit slot is the units slot showing snapshot 0 (7'h40).

Source files
------------

// File: rtl/timer_disp_pkg.sv
// Shared constants for the two-digit seven-segment scan driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package timer_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic {
        UNITS = 1'b0,
        TENS  = 1'b1
    } digit_idx_e;

    // Codes 10..15 are not BCD and render as a dash.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD to active-low seven-segment decode.
// Zero latency; no flow control.
module seg7_bcd_decode
    import timer_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_bcd];

endmodule

// File: rtl/timer_display_scan.sv
// Two-digit multiplexed seven-segment driver with frame snapshot, blanking and blinking overtime flag.
// Outputs registered; a digit appears two cycles after its slot tick; no backpressure.
module timer_display_scan
    import timer_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 25000,
    parameter int BLINK_DIV = 12500000,
    parameter bit LZB       = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Display_En,
    input  logic [3:0] TimerH,
    input  logic [3:0] TimerL,
    input  logic       Time_Over,
    output logic [6:0] Seg,
    output logic       DP,
    output logic [1:0] Dig_Sel,
    output logic       Overtime_Flag
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [SW-1:0] r_scan_cnt;
    digit_idx_e    r_idx;
    logic [3:0]    r_snap_h;
    logic [3:0]    r_snap_l;
    logic          r_to_prev;
    logic          r_flag;
    logic          r_phase;
    logic [BW-1:0] r_blink_cnt;
    logic [6:0]    r_seg;
    logic [1:0]    r_dig;

    logic          w_tick;
    logic          w_rise;
    logic          w_flag_nxt;
    logic          w_phase_nxt;
    logic [BW-1:0] w_blink_nxt;
    logic [3:0]    w_cur_bcd;
    logic [6:0]    w_dec_seg;
    logic [6:0]    w_seg_nxt;
    logic [1:0]    w_dig_nxt;

    assign w_tick    = (r_scan_cnt == SCAN_LAST);
    assign w_rise    = Time_Over & ~r_to_prev;
    assign w_cur_bcd = (r_idx == TENS) ? r_snap_h : r_snap_l;

    seg7_bcd_decode u_dec (
        .i_bcd (w_cur_bcd),
        .o_seg (w_dec_seg)
    );

    // Clear has priority over a simultaneous rising edge.
    always_comb begin
        w_flag_nxt  = r_flag;
        w_phase_nxt = r_phase;
        w_blink_nxt = r_blink_cnt;
        if (!Display_En) begin
            w_flag_nxt  = 1'b0;
            w_phase_nxt = 1'b0;
            w_blink_nxt = '0;
        end else if (!r_flag) begin
            if (w_rise) begin
                w_flag_nxt  = 1'b1;
                w_phase_nxt = 1'b1;
                w_blink_nxt = '0;
            end
        end else if (r_blink_cnt == BLINK_LAST) begin
            w_blink_nxt = '0;
            w_phase_nxt = ~r_phase;
        end else begin
            w_blink_nxt = r_blink_cnt + 1'b1;
        end
    end

    // Blink gating uses next-state so the dark phase lines up with the flag register.
    always_comb begin
        w_seg_nxt = SEG_BLANK;
        w_dig_nxt = 2'b11;
        if (Display_En && !w_tick) begin
            if (r_idx == TENS && LZB && r_snap_h == 4'd0) begin
                w_seg_nxt = SEG_BLANK;
            end else begin
                w_seg_nxt = w_dec_seg;
            end
            if (!w_flag_nxt || w_phase_nxt) begin
                w_dig_nxt = (r_idx == TENS) ? 2'b01 : 2'b10;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_scan_cnt  <= '0;
            r_idx       <= UNITS;
            r_snap_h    <= 4'd0;
            r_snap_l    <= 4'd0;
            r_to_prev   <= 1'b0;
            r_flag      <= 1'b0;
            r_phase     <= 1'b0;
            r_blink_cnt <= '0;
            r_seg       <= SEG_BLANK;
            r_dig       <= 2'b11;
        end else begin
            r_scan_cnt <= w_tick ? '0 : r_scan_cnt + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == TENS) ? UNITS : TENS;
                if (r_idx == TENS) begin
                    r_snap_h <= TimerH;
                    r_snap_l <= TimerL;
                end
            end
            r_to_prev   <= Time_Over;
            r_flag      <= w_flag_nxt;
            r_phase     <= w_phase_nxt;
            r_blink_cnt <= w_blink_nxt;
            r_seg       <= w_seg_nxt;
            r_dig       <= w_dig_nxt;
        end
    end

    assign Seg           = r_seg;
    assign Dig_Sel       = r_dig;
    assign Overtime_Flag = r_flag;
    assign DP            = 1'b1;

endmodule
